// File: rtl/timer_arb_pkg.sv
// Shared types and timer register map for the timer APB arbiter.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam logic [3:0] TMR_CNT = 4'h0;
    localparam logic [3:0] TMR_CMP = 4'h4;
    localparam logic [3:0] TMR_RLD = 4'h8;
    localparam logic [3:0] TMR_PSC = 4'hC;

endpackage

// File: rtl/timer_apb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant_idx,
    output logic          any_valid
);

    int            idx;
    logic [IW-1:0] idx_l;

    // Walk from the farthest offset down so the nearest eligible core overwrites last.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int k = N; k >= 1; k--) begin
            idx   = (int'(ptr) + k) % N;
            idx_l = IW'(idx);
            if (eligible[idx_l]) begin
                grant_idx = idx_l;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_apb_arbiter.sv
// Round-robin arbiter sharing the timer APB port among NUM_REQ cores.
// Optional request locking is enabled with `define TIMER_ARB_LOCK_EN.
module timer_apb_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = 4,
    parameter int DW      = 32
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
`ifdef TIMER_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    req_lock,
`endif
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [AW-1:0]         m_paddr,
    output logic [DW-1:0]         m_pwdata,
    input  logic [DW-1:0]         m_prdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        grant_idx;
    logic                 any_valid;
    logic [NUM_REQ-1:0]   eligible;

    logic [AW-1:0] addr_arr  [NUM_REQ];
    logic [DW-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*AW +: AW];
        assign wdata_arr[i] = req_wdata[i*DW +: DW];
    end

`ifdef TIMER_ARB_LOCK_EN
    logic          lock_active;
    logic [IW-1:0] lock_owner;

    // While locked only the owner may win; the ack mask still blocks a same-cycle regrant.
    assign eligible = req_valid & ~req_ack &
                      (lock_active ? (NUM_REQ'(1) << lock_owner) : {NUM_REQ{1'b1}});

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (state_q == ACCESS) begin
            lock_active <= req_lock[grant_q];
            lock_owner  <= grant_q;
        end
    end
`else
    assign eligible = req_valid & ~req_ack;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_psel    = 1'b0;
        m_penable = 1'b0;
        case (state_q)
            SETUP: m_psel = 1'b1;
            ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Payload is captured at grant and frozen until ACCESS exits; ack/data land on that exit edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            grant_q   <= '0;
            ptr_q     <= IW'(NUM_REQ - 1);
            req_ack   <= '0;
            rsp_rdata <= '0;
        end else begin
            req_ack <= '0;
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q  <= grant_idx;
                        m_pwrite <= req_write[grant_idx];
                        m_paddr  <= addr_arr[grant_idx];
                        m_pwdata <= wdata_arr[grant_idx];
                    end
                end
                ACCESS: begin
                    req_ack[grant_q] <= 1'b1;
                    ptr_q            <= grant_q;
                    if (!m_pwrite) rsp_rdata <= m_prdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_apb_arbiter.sv
// Scoreboard bench for timer_apb_arbiter with a small timer register model on the APB side.
module tb_timer_apb_arbiter;
    import timer_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int AW      = 4;
    localparam int DW      = 32;

    logic                  pclk  = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_write = '0;
    logic [NUM_REQ*AW-1:0] req_addr  = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
`ifdef TIMER_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    req_lock  = '0;
`endif
    logic [NUM_REQ-1:0]    req_ack;
    logic [DW-1:0]         rsp_rdata;
    logic                  m_psel, m_penable, m_pwrite;
    logic [AW-1:0]         m_paddr;
    logic [DW-1:0]         m_pwdata;
    logic [DW-1:0]         m_prdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            core;
        bit            check_rd;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   ack_cyc_q[$];
    exp_t mon_e;
    logic [NUM_REQ-1:0] mon_exp_ack;

    timer_apb_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef TIMER_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ack   (req_ack),
        .rsp_rdata (rsp_rdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Timer register model: counter is read-only, the rest are plain registers.
    logic [DW-1:0] tmr_cnt = '0, tmr_cmp = '0, tmr_rld = '0, tmr_psc = '0;

    always @(posedge pclk) begin
        tmr_cnt <= tmr_cnt + 1;
        if (m_psel && m_penable && m_pwrite) begin
            case (m_paddr)
                TMR_CMP: tmr_cmp <= m_pwdata;
                TMR_RLD: tmr_rld <= m_pwdata;
                TMR_PSC: tmr_psc <= m_pwdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        m_prdata = '0;
        case (m_paddr)
            TMR_CNT: m_prdata = tmr_cnt;
            TMR_CMP: m_prdata = tmr_cmp;
            TMR_RLD: m_prdata = tmr_rld;
            TMR_PSC: m_prdata = tmr_psc;
            default: m_prdata = '0;
        endcase
    end

    // Monitor: every ack is matched against the oldest expected completion.
    always @(negedge pclk) begin
        if (rst_n && req_ack != '0) begin
            ack_cyc_q.push_back(cyc);
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_ack: req_ack=%b, nothing expected", req_ack);
            end else begin
                mon_e       = sb_q.pop_front();
                mon_exp_ack = NUM_REQ'(1) << mon_e.core;
                if (req_ack !== mon_exp_ack || (mon_e.check_rd && rsp_rdata !== mon_e.rdata)) begin
                    errors++;
                    $display("[TB] FAIL sb_ack: req_ack=%b rsp_rdata=%h, required req_ack=%b rsp_rdata=%h",
                             req_ack, rsp_rdata, mon_exp_ack, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void expect_ack(input int core, input bit check_rd, input logic [DW-1:0] rdata);
        exp_t e;
        e.core     = core;
        e.check_rd = check_rd;
        e.rdata    = rdata;
        sb_q.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // Post one transfer for a core, hold it until its ack, then drop valid on the next edge.
    task automatic applyStimulus(input int core, input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input bit lock);
        bit seen;
        req_write[core]            = wr;
        req_addr[core*AW +: AW]    = addr;
        req_wdata[core*DW +: DW]   = data;
`ifdef TIMER_ARB_LOCK_EN
        req_lock[core]             = lock;
`else
        if (lock) $display("[TB] note: lock requested without lock build");
`endif
        req_valid[core]            = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge pclk);
            if (req_ack[core]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: core %0d got no ack, required ack within 60 cycles", core);
        end
        @(posedge pclk);
        #1;
        req_valid[core] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge pclk);
        #1;
        checkOutput("rst_psel",    DW'(m_psel),    '0);
        checkOutput("rst_penable", DW'(m_penable), '0);
        checkOutput("rst_ack",     DW'(req_ack),   '0);
        checkOutput("rst_rdata",   rsp_rdata,      '0);
        checkOutput("rst_paddr",   DW'(m_paddr),   '0);
        checkOutput("rst_pwrite",  DW'(m_pwrite),  '0);
        rst_n = 1'b1;
        @(posedge pclk);
        #1;

        // Core0 write with cycle-accurate APB phase checks.
        expect_ack(0, 1'b0, '0);
        fork
            applyStimulus(0, 1'b1, TMR_CMP, 32'h20, 1'b0);
            begin
                @(negedge pclk);
                checkOutput("t0_psel_idle", DW'(m_psel), '0);
                @(negedge pclk);
                checkOutput("t1_psel",    DW'(m_psel),    32'd1);
                checkOutput("t1_penable", DW'(m_penable), '0);
                checkOutput("t1_paddr",   DW'(m_paddr),   32'h4);
                checkOutput("t1_pwdata",  m_pwdata,       32'h20);
                checkOutput("t1_pwrite",  DW'(m_pwrite),  32'd1);
                @(negedge pclk);
                checkOutput("t2_psel",    DW'(m_psel),    32'd1);
                checkOutput("t2_penable", DW'(m_penable), 32'd1);
                @(negedge pclk);
                checkOutput("t3_ack",     DW'(req_ack),   32'h1);
                checkOutput("t3_psel",    DW'(m_psel),    '0);
            end
        join
        expect_ack(0, 1'b1, 32'h20);
        applyStimulus(0, 1'b0, TMR_CMP, '0, 1'b0);

        // All four cores contend from reset: order 0,1,2,3,0 with 3-cycle spacing.
        do_reset();
        ack_cyc_q.delete();
        expect_ack(0, 1'b0, '0);
        expect_ack(1, 1'b0, '0);
        expect_ack(2, 1'b1, 32'h20);
        expect_ack(3, 1'b1, 32'h11);
        expect_ack(0, 1'b1, 32'h22);
        fork
            begin
                applyStimulus(0, 1'b1, TMR_PSC, 32'h11, 1'b0);
                applyStimulus(0, 1'b0, TMR_RLD, '0, 1'b0);
            end
            applyStimulus(1, 1'b1, TMR_RLD, 32'h22, 1'b0);
            applyStimulus(2, 1'b0, TMR_CMP, '0, 1'b0);
            applyStimulus(3, 1'b0, TMR_PSC, '0, 1'b0);
        join
        checkOutput("rr_ack_count", DW'(ack_cyc_q.size()), 32'd5);
        for (int i = 1; i < 5 && i < ack_cyc_q.size(); i++)
            checkOutput("rr_spacing", DW'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);

        // Reload written by core1, read back by core2.
        expect_ack(1, 1'b0, '0);
        applyStimulus(1, 1'b1, TMR_RLD, 32'h55, 1'b0);
        expect_ack(2, 1'b1, 32'h55);
        applyStimulus(2, 1'b0, TMR_RLD, '0, 1'b0);

        // Core1 withdraws before grant; pending core3 wins and reads back core0's write.
        expect_ack(0, 1'b0, '0);
        expect_ack(3, 1'b1, 32'h7);
        fork
            applyStimulus(0, 1'b1, TMR_PSC, 32'h7, 1'b0);
            begin
                @(posedge pclk);
                #1;
                req_write[1]       = 1'b1;
                req_addr[1*AW +: AW] = TMR_CMP;
                req_valid[1]       = 1'b1;
                @(posedge pclk);
                #1;
                req_valid[1]       = 1'b0;
            end
            begin
                @(posedge pclk);
                #1;
                applyStimulus(3, 1'b0, TMR_PSC, '0, 1'b0);
            end
        join

        // Park the pointer on core1, then abort a core1 write with reset during ACCESS.
        expect_ack(1, 1'b0, '0);
        applyStimulus(1, 1'b1, TMR_RLD, 32'h66, 1'b0);
        req_write[1]           = 1'b1;
        req_addr[1*AW +: AW]   = TMR_PSC;
        req_wdata[1*DW +: DW]  = 32'h99;
        req_valid[1]           = 1'b1;
        repeat (3) @(negedge pclk);
        checkOutput("abort_in_access", DW'(m_penable), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_psel",    DW'(m_psel),    '0);
        checkOutput("abort_penable", DW'(m_penable), '0);
        checkOutput("abort_ack",     DW'(req_ack),   '0);
        req_valid[1] = 1'b0;
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        expect_ack(0, 1'b1, 32'h7);
        expect_ack(2, 1'b1, 32'h66);
        fork
            applyStimulus(0, 1'b0, TMR_PSC, '0, 1'b0);
            applyStimulus(2, 1'b0, TMR_RLD, '0, 1'b0);
        join

`ifdef TIMER_ARB_LOCK_EN
        // Core1 holds the lock across three writes; core0 waits and then sees the last one.
        expect_ack(1, 1'b0, '0);
        expect_ack(1, 1'b0, '0);
        expect_ack(1, 1'b0, '0);
        expect_ack(0, 1'b1, 32'h33);
        fork
            begin
                applyStimulus(1, 1'b1, TMR_PSC, 32'h31, 1'b1);
                applyStimulus(1, 1'b1, TMR_PSC, 32'h32, 1'b1);
                applyStimulus(1, 1'b1, TMR_PSC, 32'h33, 1'b0);
            end
            begin
                @(posedge pclk);
                #1;
                applyStimulus(0, 1'b0, TMR_PSC, '0, 1'b0);
            end
        join
`endif

        repeat (5) @(posedge pclk);
        #1;
        checkOutput("sb_drained", DW'(sb_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
